// File: rtl/param_counter.sv
// Parametrised up/down event counter with clear, load, wrap/one-shot modes and a terminal-count pulse.
// Optional prescaler enabled by defining COUNTER_PRESCALE_EN.
module param_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             rst_tb,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             oneshot,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  // Elaboration-time parameter legality checks
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_counter: WIDTH must be in 1..32");
  end
  if (64'(MAX_COUNT) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("param_counter: MAX_COUNT exceeds 2**WIDTH-1");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be in 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           r_state;
  logic             w_tick;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_term;
  logic             w_arrive;
  logic [WIDTH-1:0] w_load_sat;

`ifdef COUNTER_PRESCALE_EN
  logic [15:0] r_pre;

  assign w_tick = (r_pre == 16'(PRESCALE - 1));

  // Prescaler phase: advances on enabled edges, cleared by clear/load
  always_ff @(posedge clk or negedge rst_tb) begin
    if (!rst_tb) begin
      r_pre <= '0;
    end else if (clear || load) begin
      r_pre <= '0;
    end else if (enable && (r_state != S_STOP)) begin
      r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  assign w_step     = enable && (r_state != S_STOP) && w_tick;
  assign w_term     = dir ? MAX_V : '0;
  assign w_load_sat = (load_val > MAX_V) ? MAX_V : load_val;
  assign w_arrive   = (w_next == w_term);

  // Next count value for a step, modulo MAX_COUNT+1, holding at the end in one-shot
  always_comb begin
    w_next = out;
    if (dir) begin
      if (out == MAX_V) w_next = oneshot ? out : '0;
      else              w_next = out + WIDTH'(1);
    end else begin
      if (out == '0)    w_next = oneshot ? out : MAX_V;
      else              w_next = out - WIDTH'(1);
    end
  end

  // Control FSM with registered count, done pulse and busy flag
  always_ff @(posedge clk or negedge rst_tb) begin
    if (!rst_tb) begin
      r_state <= S_IDLE;
      out     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      out     <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      r_state <= S_IDLE;
      out     <= w_load_sat;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else if (w_step) begin
      out  <= w_next;
      done <= w_arrive;
      if (w_arrive && oneshot) begin
        r_state <= S_STOP;
        busy    <= 1'b0;
      end else begin
        r_state <= S_RUN;
        busy    <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: vector table on a MAX_COUNT=9 instance plus
// hand-written sequences for wrap, async reset and (when enabled) prescaling.
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst_tb;
  logic       enable, clear, load, dir, oneshot;
  logic [3:0] load_val;
  logic [3:0] out15, out9;
  logic       done15, busy15, done9, busy9;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(1)) dut15 (
    .clk(clk), .rst_tb(rst_tb), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .oneshot(oneshot),
    .out(out15), .done(done15), .busy(busy15)
  );

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1)) dut9 (
    .clk(clk), .rst_tb(rst_tb), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .oneshot(oneshot),
    .out(out9), .done(done9), .busy(busy9)
  );

`ifdef COUNTER_PRESCALE_EN
  logic [3:0] out_p;
  logic       done_p, busy_p;
  param_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(3)) dut_p (
    .clk(clk), .rst_tb(rst_tb), .enable(enable), .clear(clear), .load(load),
    .load_val(load_val), .dir(dir), .oneshot(oneshot),
    .out(out_p), .done(done_p), .busy(busy_p)
  );
`endif

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       dr;
    logic       os;
    logic [3:0] o;
    logic       d;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int clr, input int ld, input int lv, input int en,
                     input int dr, input int os, input int o, input int d, input int b);
    vec_t v;
    v.clr = 1'(clr); v.ld = 1'(ld); v.lv = 4'(lv); v.en = 1'(en);
    v.dr  = 1'(dr);  v.os = 1'(os); v.o  = 4'(o);  v.d  = 1'(d);  v.b = 1'(b);
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return 1ns after the rising edge
  task automatic cyc(input int clr, input int ld, input int lv, input int en,
                     input int dr, input int os);
    @(negedge clk);
    clear = 1'(clr); load = 1'(ld); load_val = 4'(lv);
    enable = 1'(en); dir = 1'(dr); oneshot = 1'(os);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_tb = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    load_val = '0; dir = 1'b1; oneshot = 1'b0;
    #1 rst_tb = 1'b0;
    #1;
    chk("reset out", int'(out15), 0);
    chk("reset done", int'(done15), 0);
    chk("reset busy", int'(busy15), 0);
    @(negedge clk);
    rst_tb = 1'b1;

    // Free-run up, MAX=15: 1..15 then 0..4, done only while out==15
    cyc(1, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 1, 1, 0);
      chk($sformatf("wrap15 out[%0d]", i), int'(out15), i % 16);
      chk($sformatf("wrap15 done[%0d]", i), int'(done15), (i % 16 == 15) ? 1 : 0);
      chk($sformatf("wrap15 busy[%0d]", i), int'(busy15), 1);
    end

    //   clr ld lv en dr os   out done busy   (MAX_COUNT=9 instance)
    add(1, 0, 0, 0, 1, 1,   0, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 1, 1, 1, k, 0, 1);
    add(0, 0, 0, 1, 1, 1,   9, 1, 0);   // one-shot arrival -> STOP
    add(0, 0, 0, 1, 1, 1,   9, 0, 0);   // enable ignored in STOP
    add(0, 0, 0, 1, 1, 1,   9, 0, 0);
    add(1, 0, 0, 0, 1, 1,   0, 0, 0);
    add(0, 1, 3, 0, 0, 0,   3, 0, 0);   // down, free-run from 3
    add(0, 0, 0, 1, 0, 0,   2, 0, 1);
    add(0, 0, 0, 1, 0, 0,   1, 0, 1);
    add(0, 0, 0, 1, 0, 0,   0, 1, 1);
    add(0, 0, 0, 1, 0, 0,   9, 0, 1);
    add(0, 0, 0, 1, 0, 0,   8, 0, 1);
    add(0, 1, 12, 0, 0, 0,  9, 0, 0);   // saturating load, no done
    add(0, 1, 12, 1, 1, 0,  9, 0, 0);   // load to terminal with enable: no done
    add(1, 0, 0, 0, 1, 0,   0, 0, 0);
    for (int k = 1; k <= 5; k++) add(0, 0, 0, 1, 1, 0, k, 0, 1);
    add(1, 1, 7, 1, 1, 0,   0, 0, 0);   // clear beats load and enable
    add(0, 1, 7, 1, 1, 0,   7, 0, 0);   // load beats enable
    add(0, 0, 0, 1, 1, 0,   8, 0, 1);
    add(0, 0, 0, 1, 1, 0,   9, 1, 1);
    add(0, 0, 0, 1, 1, 0,   0, 0, 1);
    add(0, 0, 0, 0, 1, 0,   0, 0, 1);   // pause stays RUN
    add(0, 0, 0, 1, 0, 0,   9, 0, 1);   // dir flip takes effect immediately

    foreach (vecs[i]) begin
      cyc(int'(vecs[i].clr), int'(vecs[i].ld), int'(vecs[i].lv),
          int'(vecs[i].en), int'(vecs[i].dr), int'(vecs[i].os));
      chk($sformatf("vec%0d out", i), int'(out9), int'(vecs[i].o));
      chk($sformatf("vec%0d done", i), int'(done9), int'(vecs[i].d));
      chk($sformatf("vec%0d busy", i), int'(busy9), int'(vecs[i].b));
    end

    // Asynchronous reset mid-count at out==6
    cyc(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1, 0);
    chk("pre-reset out", int'(out15), 6);
    @(negedge clk);
    #2 rst_tb = 1'b0;
    #1;
    chk("async reset out", int'(out15), 0);
    chk("async reset done", int'(done15), 0);
    chk("async reset busy", int'(busy15), 0);
    @(negedge clk);
    rst_tb = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset out", int'(out15), 1);
    chk("post-reset busy", int'(busy15), 1);

`ifdef COUNTER_PRESCALE_EN
    // PRESCALE=3: a step every third enabled edge; enable low holds phase
    cyc(1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 1, 1, 0);
      chk($sformatf("pre out[%0d]", k), int'(out_p), k / 3);
    end
    cyc(0, 0, 0, 1, 1, 0);
    chk("pre phase1 out", int'(out_p), 3);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("pre hold out", int'(out_p), 3);
    cyc(0, 0, 0, 1, 1, 0);
    chk("pre phase2 out", int'(out_p), 3);
    cyc(0, 0, 0, 1, 1, 0);
    chk("pre resume out", int'(out_p), 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
